// File: rtl/lsu_pkg.sv
// Shared types and RV32I funct3 width/sign codes for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_dmem_if.sv
// Core <-> load/store unit request/response bus.
interface lsu_dmem_if;

   logic        req_valid;
   logic        req_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        misalign_err;
   logic        stall;

   modport master (
      output req_valid, req_we, funct3, addr, wdata,
      input  req_ready, rsp_valid, rdata, misalign_err, stall
   );

   modport slave (
      input  req_valid, req_we, funct3, addr, wdata,
      output req_ready, rsp_valid, rdata, misalign_err, stall
   );

endinterface

// File: rtl/dmem_bank.sv
// Word-organised synchronous RAM with per-byte write enables and 1-cycle read.
module dmem_bank #(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit: latches one request, performs it against dmem_bank, and
// returns an extended load result two cycles after acceptance.
module lsu_dmem
   import lsu_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
) (
   input  logic         clk,
   input  logic         reset,
   lsu_dmem_if.slave    bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 1'b0;
         2'b01:   return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[8*off +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_BU:   return {24'h0, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_HU:   return {16'h0, h};
         default: return word;
      endcase
   endfunction

   lsu_state_t       state;
   logic             req_we_p0;
   logic [2:0]       funct3_p0;
   logic [IDX_W+1:0] addr_p0;
   logic [31:0]      wdata_p0;
   logic             err_p0;
   logic [3:0]       be;
   logic [31:0]      lane_data;
   logic             ram_we;
   logic [31:0]      ram_word;
   logic             unused_addr;

   assign unused_addr = ^bus.addr[31:IDX_W+2];

   // Request capture: only on the accept edge
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.req_valid) begin
         req_we_p0 <= bus.req_we;
         funct3_p0 <= bus.funct3;
         addr_p0   <= bus.addr[IDX_W+1:0];
         wdata_p0  <= bus.wdata;
         err_p0    <= is_misaligned(bus.funct3, bus.addr[1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state            <= IDLE;
         bus.req_ready    <= 1'b1;
         bus.rsp_valid    <= 1'b0;
         bus.misalign_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  state         <= ACCESS;
                  bus.req_ready <= 1'b0;
               end
            end
            ACCESS: begin
               state            <= RESP;
               bus.rsp_valid    <= 1'b1;
               bus.misalign_err <= err_p0;
            end
            default: begin
               state            <= IDLE;
               bus.rsp_valid    <= 1'b0;
               bus.misalign_err <= 1'b0;
               bus.req_ready    <= 1'b1;
            end
         endcase
      end
   end

   // Byte lanes are replicated so the enable mask alone selects the target bytes
   always_comb begin
      be        = 4'b1111;
      lane_data = wdata_p0;
      case (funct3_p0[1:0])
         2'b00: begin
            be        = 4'b0001 << addr_p0[1:0];
            lane_data = {4{wdata_p0[7:0]}};
         end
         2'b01: begin
            be        = 4'b0011 << addr_p0[1:0];
            lane_data = {2{wdata_p0[15:0]}};
         end
         default: ;
      endcase
   end

   // Reset low on the ACCESS edge must suppress the write
   assign ram_we = reset && (state == ACCESS) && req_we_p0 && !err_p0;

   dmem_bank #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_bank (
      .clk   (clk),
      .we    (ram_we),
      .be    (be),
      .idx   (addr_p0[IDX_W+1:2]),
      .wdata (lane_data),
      .rdata (ram_word)
   );

   assign bus.stall = (state == IDLE && bus.req_valid) || (state == ACCESS);
   assign bus.rdata = (bus.rsp_valid && !req_we_p0 && !err_p0)
                      ? load_ext(ram_word, funct3_p0, addr_p0[1:0]) : 32'h0;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: handshake timing, width/extension, misalignment, wrap, reset.
module tb_lsu_dmem;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;
   logic [31:0] rd;
   logic        er;

   lsu_dmem_if bus();

   lsu_dmem #(.DEPTH_WORDS(256)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transaction with handshake/stall timing checks.
   task automatic access(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output logic err);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.funct3    = f3;
      bus.addr      = a;
      bus.wdata     = d;
      #1;
      chk({tag, "_stall_idle"}, {31'h0, bus.stall}, 32'h1);
      chk({tag, "_ready_idle"}, {31'h0, bus.req_ready}, 32'h1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.addr      = 32'hFFFF_FFFF;
      bus.wdata     = ~d;
      bus.funct3    = 3'b111;
      #1;
      chk({tag, "_stall_access"}, {31'h0, bus.stall}, 32'h1);
      chk({tag, "_rsp_early"}, {31'h0, bus.rsp_valid}, 32'h0);
      chk({tag, "_ready_access"}, {31'h0, bus.req_ready}, 32'h0);
      @(negedge clk);
      chk({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
      chk({tag, "_stall_resp"}, {31'h0, bus.stall}, 32'h0);
      rdata = bus.rdata;
      err   = bus.misalign_err;
      @(negedge clk);
      chk({tag, "_rsp_pulse"}, {31'h0, bus.rsp_valid}, 32'h0);
      chk({tag, "_ready_back"}, {31'h0, bus.req_ready}, 32'h1);
   endtask

   initial begin
      n_chk         = 0;
      n_fail        = 0;
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.funct3    = 3'b010;
      bus.addr      = 32'h0;
      bus.wdata     = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("rst_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_err", {31'h0, bus.misalign_err}, 32'h0);
      chk("rst_stall", {31'h0, bus.stall}, 32'h0);
      reset = 1'b1;

      access("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
      chk("sw10_rdata", rd, 32'h0);
      chk("sw10_err", {31'h0, er}, 32'h0);
      access("lw10", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
      chk("lw10_rdata", rd, 32'hDEADBEEF);

      access("lb13", 1'b0, 3'b000, 32'h13, 32'h0, rd, er);
      chk("lb13_rdata", rd, 32'hFFFFFFDE);
      access("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, rd, er);
      chk("lbu13_rdata", rd, 32'h000000DE);
      access("lh12", 1'b0, 3'b001, 32'h12, 32'h0, rd, er);
      chk("lh12_rdata", rd, 32'hFFFFDEAD);
      access("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, rd, er);
      chk("lhu10_rdata", rd, 32'h0000BEEF);
      access("lb10", 1'b0, 3'b000, 32'h10, 32'h0, rd, er);
      chk("lb10_rdata", rd, 32'hFFFFFFEF);

      access("sb11", 1'b1, 3'b000, 32'h11, 32'h000000AA, rd, er);
      access("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
      chk("lw10b_rdata", rd, 32'hDEADAAEF);
      access("sh12", 1'b1, 3'b001, 32'h12, 32'h00001234, rd, er);
      access("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
      chk("lw10c_rdata", rd, 32'h1234AAEF);

      access("lw12mis", 1'b0, 3'b010, 32'h12, 32'h0, rd, er);
      chk("lw12mis_err", {31'h0, er}, 32'h1);
      chk("lw12mis_rdata", rd, 32'h0);
      access("sh11mis", 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, rd, er);
      chk("sh11mis_err", {31'h0, er}, 32'h1);
      chk("sh11mis_rdata", rd, 32'h0);
      access("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
      chk("lw10d_rdata", rd, 32'h1234AAEF);
      chk("lw10d_err", {31'h0, er}, 32'h0);

      access("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, rd, er);
      chk("f3_011_rdata", rd, 32'h1234AAEF);
      access("f3_111mis", 1'b0, 3'b111, 32'h11, 32'h0, rd, er);
      chk("f3_111mis_err", {31'h0, er}, 32'h1);

      access("sw400", 1'b1, 3'b010, 32'h400, 32'h00000055, rd, er);
      access("lw0", 1'b0, 3'b010, 32'h0, 32'h0, rd, er);
      chk("wrap_rdata", rd, 32'h00000055);

      // Store aborted by reset on its ACCESS edge
      access("sw20z", 1'b1, 3'b010, 32'h20, 32'h0, rd, er);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.funct3    = 3'b010;
      bus.addr      = 32'h20;
      bus.wdata     = 32'h1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      reset         = 1'b0;
      @(negedge clk);
      chk("rstmid_rsp", {31'h0, bus.rsp_valid}, 32'h0);
      chk("rstmid_ready", {31'h0, bus.req_ready}, 32'h1);
      chk("rstmid_stall", {31'h0, bus.stall}, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_rsp2", {31'h0, bus.rsp_valid}, 32'h0);
      access("lw20", 1'b0, 3'b010, 32'h20, 32'h0, rd, er);
      chk("lw20_rdata", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Load/store unit plus byte-addressed data RAM. Sits directly downstream of the single-cycle datapath.
- Consumes the ALU address, the store data and funct3; returns the sign/zero-extended load result to the write-back mux (rd select 01).
- Adds a registered request/response handshake and a stall output, so the core freezes its PC while a memory access is in flight.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM; must be a power of 2.
- IDX_W, $clog2(DEPTH_WORDS), word-index width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: clears the FSM when low at a rising clk edge.
- req_valid  in  1  core presents a load or store this cycle.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- req_ready  out  1  unit can accept a request.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rdata  out  32  extended load data; valid while rsp_valid=1.
- misalign_err  out  1  with rsp_valid: request was misaligned and not performed.
- stall  out  1  core must hold its PC and must not write back.

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rdata=0, misalign_err=0, stall=0. RAM contents are not cleared by reset; simulation initial value is all zeros.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch req_we, funct3, addr, wdata and go to ACCESS.
  - Misalignment check on the latched request: halfword with addr[0]=1, or word with addr[1:0]!=0. If misaligned, set the err flag.
- ACCESS:
  - req_ready=0.
  - Store without err: write the RAM word at addr[IDX_W+1:2] with byte enables:
    - SB: 0001 << addr[1:0]
    - SH: 0011 << addr[1:0]
    - SW: 1111
    - Lane data is replicated: SB puts wdata[7:0] in every lane; SH puts wdata[15:0] in both halves.
  - Load: issue a synchronous RAM read (1-cycle latency).
  - Go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - Load: select the byte/halfword by addr[1:0]/addr[1]. Sign-extend for 000/001; zero-extend for 100/101; pass the word through for 010.
  - Store: rdata=0.
  - err: no RAM write, rdata=0, misalign_err=1.
  - Go to IDLE.
- Latency: request accepted at edge T; rsp_valid is high during cycle T+2; the next request can be accepted at edge T+3.
- Stall: stall = (state==IDLE && req_valid) || state==ACCESS. Stall is low in RESP so the core advances and writes back in that cycle.
- req_valid is ignored outside IDLE. Request inputs are sampled only on the accept edge; changes after acceptance have no effect.
- Undefined funct3 (011, 110, 111) is treated as LW/SW width with the word alignment rule.
- Address wrap: addr bits above IDX_W+1 are ignored, so addresses alias modulo 4*DEPTH_WORDS.
- Reset low mid-operation:
  - FSM returns to IDLE and rsp_valid drops on that edge.
  - A store whose ACCESS edge coincides with reset low must NOT write.
  - A store whose ACCESS edge has already completed stays written.
- Back-to-back: req_valid held high through RESP is accepted again in the following IDLE cycle. Each accept produces exactly one response.

Decomposition:
- Shared package lsu_pkg holds:
  - enum lsu_state_t {IDLE, ACCESS, RESP}
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
- One sub-module, dmem_bank: DEPTH_WORDS x 32 synchronous RAM with 4-bit byte enables, 1-cycle read, no reset.
- Alignment logic, byte-enable generation, lane replication and load extension stay in lsu_dmem.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> rsp_valid two cycles after each accept; rdata=0xDEADBEEF; stall high exactly 2 cycles per access.
- After the word above: LB addr=0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB addr=0x11 wdata=0x000000AA, then LW 0x10 -> 0xDEADAAEF (only byte 1 changed). SH addr=0x12 wdata=0x1234, then LW 0x10 -> 0x1234AAEF.
- LW addr=0x12 and SH addr=0x11 -> each gives rsp_valid=1 with misalign_err=1, rdata=0; a following LW 0x10 still returns 0x1234AAEF.
- Address wrap with DEPTH_WORDS=256: SW addr=0x400 wdata=0x55 -> LW addr=0x0 returns 0x00000055.
- Reset low on the SW ACCESS edge (SW addr=0x20 wdata=0x1) -> state IDLE, no rsp_valid, req_ready=1 next cycle; LW 0x20 then returns the prior value 0x0.
